iso_seq_ctrl: RTL

Parametrised power-domain isolation sequencer for `NUM_DOM` switchable domains. Per domain it orders isolation and power-switch control: isolate before power-off, and power-up plus settle before de-isolation. It also provides the clamped, isolated data path from each domain into the always-on logic. It replaces hand-instanced isolation cells with per-cell enable polarity and fixed clamp type, and adds handshaked sequencing, per-domain clamp mode and timeout reporting.

---
 rtl/iso_seq_pkg.sv | 22 ++
 rtl/iso_seq_dom.sv | 135 +++++++++++++
 rtl/iso_seq_ctrl.sv | 54 +++++
 3 files changed

// File: rtl/iso_seq_pkg.sv
// Shared types and sizing helpers for the power-domain isolation sequencer.
package iso_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PUP    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_ISO    = 3'd4,
        ST_PDN    = 3'd5
    } iso_state_t;

    // One counter serves setup, settle and ack-timeout, so size it for the largest load.
    function automatic int cnt_width(input int setup_cyc, input int settle_cyc, input int ack_timeout);
        int m;
        m = setup_cyc;
        if (settle_cyc > m) m = settle_cyc;
        if (ack_timeout > m) m = ack_timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/iso_seq_dom.sv
// One switchable domain: isolation/power sequencing FSM, shared down-counter,
// sticky timeout flag, hold register and the clamp/hold output mux.
//
// state  | meaning
// OFF    | rail off, isolated; waits for request with no pending error
// PUP    | switch enabled, waiting for rail-good ack (timeout guarded)
// SETTLE | rail good, isolation held for the settle time
// ON     | isolation released, data passes through
// ISO    | isolation applied, held for setup time before switching off
// PDN    | switch disabled, waiting for ack to drop (timeout guarded)
module iso_seq_dom
    import iso_seq_pkg::*;
#(
    parameter int   DW          = 8,
    parameter int   SETUP_CYC   = 2,
    parameter int   SETTLE_CYC  = 4,
    parameter int   ACK_TIMEOUT = 255,
    parameter logic CLAMP_HI    = 1'b0,
    parameter logic HOLD_MODE   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwr_req,
    input  logic          pwr_ack,
    input  logic          err_clr,
    input  logic [DW-1:0] din,
    output logic          pwr_en,
    output logic          iso_en,
    output logic          dom_on,
    output logic          err,
    output logic [DW-1:0] dout
);

    localparam int CW = cnt_width(SETUP_CYC, SETTLE_CYC, ACK_TIMEOUT);

    iso_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          cnt_tc;
    logic          err_set, err_nxt;
    logic          hold_ld;
    logic [DW-1:0] hold_q;
    logic          pwr_en_nxt, iso_en_nxt, dom_on_nxt;

    assign cnt_tc = (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_set   = 1'b0;
        hold_ld   = 1'b0;
        case (state)
            ST_OFF: begin
                if (pwr_req && !err) begin
                    state_nxt = ST_PUP;
                    cnt_nxt   = CW'(ACK_TIMEOUT);
                end
            end
            ST_PUP: begin
                if (pwr_ack) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CW'(SETTLE_CYC);
                end else if (cnt_tc) begin
                    err_set   = 1'b1;
                    state_nxt = ST_PDN;
                    cnt_nxt   = CW'(ACK_TIMEOUT);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_tc) state_nxt = ST_ON;
                else        cnt_nxt   = cnt - CW'(1);
            end
            ST_ON: begin
                if (!pwr_req) begin
                    state_nxt = ST_ISO;
                    cnt_nxt   = CW'(SETUP_CYC);
                    hold_ld   = 1'b1;
                end
            end
            ST_ISO: begin
                if (cnt_tc) begin
                    state_nxt = ST_PDN;
                    cnt_nxt   = CW'(ACK_TIMEOUT);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_PDN: begin
                if (!pwr_ack) begin
                    state_nxt = ST_OFF;
                end else if (cnt_tc) begin
                    err_set   = 1'b1;
                    state_nxt = ST_OFF;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = ST_OFF;
        endcase

        // Clear wins over a coincident timeout.
        err_nxt    = err_clr ? 1'b0 : (err | err_set);
        pwr_en_nxt = (state_nxt != ST_OFF) && (state_nxt != ST_PDN);
        iso_en_nxt = (state_nxt != ST_ON);
        dom_on_nxt = (state_nxt == ST_ON);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_OFF;
            cnt    <= '0;
            err    <= 1'b0;
            pwr_en <= 1'b0;
            iso_en <= 1'b1;
            dom_on <= 1'b0;
            hold_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            err    <= err_nxt;
            pwr_en <= pwr_en_nxt;
            iso_en <= iso_en_nxt;
            dom_on <= dom_on_nxt;
            if (hold_ld) hold_q <= din;
        end
    end

    always_comb begin
        if (!iso_en)        dout = din;
        else if (HOLD_MODE) dout = hold_q;
        else                dout = {DW{CLAMP_HI}};
    end

endmodule

// File: rtl/iso_seq_ctrl.sv
// Isolation sequencer for NUM_DOM switchable domains; each domain is an
// independent iso_seq_dom, with err_clr shared by all.
module iso_seq_ctrl
    import iso_seq_pkg::*;
#(
    parameter int                 NUM_DOM     = 4,
    parameter int                 DW          = 8,
    parameter int                 SETUP_CYC   = 2,
    parameter int                 SETTLE_CYC  = 4,
    parameter int                 ACK_TIMEOUT = 255,
    parameter logic [NUM_DOM-1:0] CLAMP_HI    = '0,
    parameter logic [NUM_DOM-1:0] HOLD_MODE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DOM-1:0]    pwr_req,
    input  logic [NUM_DOM-1:0]    pwr_ack,
    input  logic                  err_clr,
    input  logic [NUM_DOM*DW-1:0] din,
    output logic [NUM_DOM-1:0]    pwr_en,
    output logic [NUM_DOM-1:0]    iso_en,
    output logic [NUM_DOM-1:0]    iso_n,
    output logic [NUM_DOM-1:0]    dom_on,
    output logic [NUM_DOM-1:0]    err,
    output logic [NUM_DOM*DW-1:0] dout
);

    for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
        iso_seq_dom #(
            .DW          (DW),
            .SETUP_CYC   (SETUP_CYC),
            .SETTLE_CYC  (SETTLE_CYC),
            .ACK_TIMEOUT (ACK_TIMEOUT),
            .CLAMP_HI    (CLAMP_HI[d]),
            .HOLD_MODE   (HOLD_MODE[d])
        ) u_dom (
            .clk     (clk),
            .rst     (rst),
            .pwr_req (pwr_req[d]),
            .pwr_ack (pwr_ack[d]),
            .err_clr (err_clr),
            .din     (din[d*DW +: DW]),
            .pwr_en  (pwr_en[d]),
            .iso_en  (iso_en[d]),
            .dom_on  (dom_on[d]),
            .err     (err[d]),
            .dout    (dout[d*DW +: DW])
        );
    end

    // Inverted enable for isolation cells with an active-low pin.
    assign iso_n = ~iso_en;

endmodule
